// File: rtl/memory_controller.sv
`default_nettype none
// ============================================================================
// Module      : memory_controller
// Description : Single-port memory controller. A direct-mapped L1 cache sits
//               in front of an on-chip backing word memory. The cache is
//               write-through and write-allocate. A read miss stalls the
//               controller for MISS_LATENCY cycles, then refills the line and
//               returns the word.
//
// Ports       : clk       - clock; all state changes on the rising edge
//               reset_n   - synchronous reset, ACTIVE-HIGH despite its name
//               enable    - request valid, sampled at the rising edge
//               rw        - 1 = write, 0 = read
//               address   - byte address; bits [1:0] are ignored
//               data_in   - write data
//               data_out  - registered read data; holds until next read
//               ready     - 1 when idle and able to accept a request
//               hit       - one-cycle pulse following a read-hit edge
//
// Revision    : 1.0 - initial release
// ============================================================================
module memory_controller #(
    parameter int ADDR_WIDTH    = 32,
    parameter int DATA_WIDTH    = 32,
    parameter int INDEX_BITS    = 4,
    parameter int MEM_ADDR_BITS = 10,
    parameter int MISS_LATENCY  = 2
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  enable,
    input  logic                  rw,
    input  logic [ADDR_WIDTH-1:0] address,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  ready,
    output logic                  hit
);

    // ------------------------------------------------------------------------
    // Derived sizes
    // ------------------------------------------------------------------------
    localparam int c_LINES     = 1 << INDEX_BITS;
    localparam int c_MEM_WORDS = 1 << MEM_ADDR_BITS;
    localparam int c_TAG_W     = ADDR_WIDTH - INDEX_BITS - 2;
    // Counter holds MISS_LATENCY-1 down to 0; keep at least one bit.
    localparam int c_CNT_W     = (MISS_LATENCY > 1) ? $clog2(MISS_LATENCY) : 1;

    localparam logic [c_CNT_W-1:0] c_CNT_LOAD = c_CNT_W'(MISS_LATENCY - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);
    localparam logic [c_CNT_W-1:0] c_CNT_ZERO = '0;

    // ------------------------------------------------------------------------
    // State encoding
    // ------------------------------------------------------------------------
    localparam logic [1:0] c_S_IDLE      = 2'd0;
    localparam logic [1:0] c_S_MISS_WAIT = 2'd1;
    localparam logic [1:0] c_S_FILL      = 2'd2;

    // ------------------------------------------------------------------------
    // Storage
    // ------------------------------------------------------------------------
    // Backing memory starts at zero and is never cleared by reset.
    logic [DATA_WIDTH-1:0] r_mem [0:c_MEM_WORDS-1] = '{default: '0};

    logic [c_LINES-1:0]    r_valid;
    logic [c_TAG_W-1:0]    r_tag  [0:c_LINES-1];
    logic [DATA_WIDTH-1:0] r_data [0:c_LINES-1];

    // ------------------------------------------------------------------------
    // Control registers
    // ------------------------------------------------------------------------
    logic [1:0]               r_state;
    logic [c_CNT_W-1:0]       r_cnt;
    logic [INDEX_BITS-1:0]    r_miss_index;
    logic [c_TAG_W-1:0]       r_miss_tag;
    logic [MEM_ADDR_BITS-1:0] r_miss_word;
    logic [DATA_WIDTH-1:0]    r_data_out;
    logic                     r_ready;
    logic                     r_hit;

    // ------------------------------------------------------------------------
    // Address decode
    // ------------------------------------------------------------------------
    logic [INDEX_BITS-1:0]    w_index;
    logic [c_TAG_W-1:0]       w_tag;
    logic [MEM_ADDR_BITS-1:0] w_word;
    logic [1:0]               w_unused_offset;

    assign w_index         = address[INDEX_BITS+1:2];
    assign w_tag           = address[ADDR_WIDTH-1:INDEX_BITS+2];
    assign w_word          = address[MEM_ADDR_BITS+1:2];
    assign w_unused_offset = address[1:0];

    // ------------------------------------------------------------------------
    // Request qualification
    // ------------------------------------------------------------------------
    logic                  w_idle;
    logic                  w_accept;
    logic                  w_wr;
    logic                  w_rd;
    logic                  w_lookup_hit;
    logic                  w_fill;
    logic [DATA_WIDTH-1:0] w_fill_data;

    assign w_idle       = (r_state == c_S_IDLE);
    // A reset edge overrides any request presented at the same edge.
    assign w_accept     = w_idle && enable && !reset_n;
    assign w_wr         = w_accept && rw;
    assign w_rd         = w_accept && !rw;
    assign w_lookup_hit = r_valid[w_index] && (r_tag[w_index] == w_tag);
    // A reset landing on the FILL edge aborts the refill entirely.
    assign w_fill       = (r_state == c_S_FILL) && !reset_n;
    assign w_fill_data  = r_mem[r_miss_word];

    // ------------------------------------------------------------------------
    // Backing memory: write-through on every accepted write
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[w_word] <= data_in;
        end
    end

    // ------------------------------------------------------------------------
    // Cache tag/data arrays. Only the valid bits need resetting; tag and
    // data are meaningless while the line is invalid. CPU writes and line
    // fills are mutually exclusive because they occur in different states.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_tag[w_index]  <= w_tag;
            r_data[w_index] <= data_in;
        end else if (w_fill) begin
            r_tag[r_miss_index]  <= r_miss_tag;
            r_data[r_miss_index] <= w_fill_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset_n) begin
            r_valid <= '0;
        end else if (w_wr) begin
            r_valid[w_index] <= 1'b1;
        end else if (w_fill) begin
            r_valid[r_miss_index] <= 1'b1;
        end
    end

    // ------------------------------------------------------------------------
    // Controller FSM with registered outputs
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset_n) begin
            r_state      <= c_S_IDLE;
            r_cnt        <= c_CNT_ZERO;
            r_miss_index <= '0;
            r_miss_tag   <= '0;
            r_miss_word  <= '0;
            r_data_out   <= '0;
            r_ready      <= 1'b1;
            r_hit        <= 1'b0;
        end else begin
            // hit is a single-cycle pulse unless re-asserted below
            r_hit <= 1'b0;

            case (r_state)
                c_S_IDLE: begin
                    r_ready <= 1'b1;
                    if (w_rd) begin
                        if (w_lookup_hit) begin
                            r_data_out <= r_data[w_index];
                            r_hit      <= 1'b1;
                        end else begin
                            r_miss_index <= w_index;
                            r_miss_tag   <= w_tag;
                            r_miss_word  <= w_word;
                            r_cnt        <= c_CNT_LOAD;
                            r_ready      <= 1'b0;
                            r_state      <= c_S_MISS_WAIT;
                        end
                    end
                end

                // Requests arriving here are dropped, not queued.
                c_S_MISS_WAIT: begin
                    r_ready <= 1'b0;
                    if (r_cnt == c_CNT_ZERO) begin
                        r_state <= c_S_FILL;
                    end else begin
                        r_cnt <= r_cnt - c_CNT_ONE;
                    end
                end

                c_S_FILL: begin
                    r_data_out <= w_fill_data;
                    r_ready    <= 1'b1;
                    r_state    <= c_S_IDLE;
                end

                default: begin
                    r_ready <= 1'b1;
                    r_state <= c_S_IDLE;
                end
            endcase
        end
    end

    assign data_out = r_data_out;
    assign ready    = r_ready;
    assign hit      = r_hit;

endmodule
`default_nettype wire

// File: tb/tb_memory_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_memory_controller
// Description : Self-checking bench for memory_controller. A table of
//               read/write vectors with constant expected results is applied
//               in a loop; reads push an expectation (hit flag, data, latency)
//               onto a scoreboard queue that is popped when the DUT signals
//               completion (hit pulse or ready returning high). Hand-written
//               sequences cover held enable, dropped requests during a miss
//               and reset in the middle of a miss.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_memory_controller;

    localparam int c_MISS_LATENCY = 2;
    localparam int c_NVEC         = 18;

    logic        clk;
    logic        reset_n;
    logic        enable;
    logic        rw;
    logic [31:0] address;
    logic [31:0] data_in;
    logic [31:0] data_out;
    logic        ready;
    logic        hit;

    memory_controller #(
        .ADDR_WIDTH    (32),
        .DATA_WIDTH    (32),
        .INDEX_BITS    (4),
        .MEM_ADDR_BITS (10),
        .MISS_LATENCY  (c_MISS_LATENCY)
    ) u_dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .enable   (enable),
        .rw       (rw),
        .address  (address),
        .data_in  (data_in),
        .data_out (data_out),
        .ready    (ready),
        .hit      (hit)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Edge counter and reset-at-last-edge, both sampled on the active edge.
    int   cyc      = 0;
    logic rst_prev = 1'b1;
    always @(posedge clk) begin
        cyc      <= cyc + 1;
        rst_prev <= reset_n;
    end

    typedef struct {
        bit          rw;
        logic [31:0] addr;
        logic [31:0] wdata;
        bit          exp_hit;
        logic [31:0] exp_data;
    } vec_t;

    typedef struct {
        bit          hit;
        logic [31:0] data;
        int          lat;
        int          acc;
    } exp_t;

    vec_t        vecs [c_NVEC];
    exp_t        sb [$];
    int          n_vec = 0;
    int          n_err = 0;
    logic        prev_ready = 1'b1;
    logic [31:0] last_rd = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // One clock step; at the negedge, detect and score read completions.
    task automatic tick();
        exp_t e;
        @(negedge clk);
        if (!rst_prev && (hit || (!prev_ready && ready))) begin
            if (sb.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL spurious_completion: hit=%b ready=%b with no pending read", hit, ready);
            end else begin
                e = sb.pop_front();
                chk("rd_hit", {31'b0, hit}, {31'b0, e.hit});
                chk("rd_data", data_out, e.data);
                chk("rd_latency", cyc - e.acc, e.lat);
            end
        end
        prev_ready = ready;
    endtask

    // Expectation for a read accepted at the next active edge (offset k).
    task automatic push_exp(input bit h, input logic [31:0] d, input int k);
        exp_t e;
        e.hit  = h;
        e.data = d;
        e.lat  = h ? 0 : c_MISS_LATENCY + 1;
        e.acc  = cyc + 1 + k;
        sb.push_back(e);
        last_rd = d;
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 20 && sb.size() != 0; i++) tick();
        if (sb.size() != 0) begin
            n_vec++;
            n_err++;
            $display("FAIL timeout: %0d read(s) never completed", sb.size());
            sb.delete();
        end
    endtask

    task automatic do_write(input logic [31:0] a, input logic [31:0] d);
        enable = 1'b1; rw = 1'b1; address = a; data_in = d;
        tick();
        enable = 1'b0;
        chk("wr_hit", {31'b0, hit}, 32'd0);
        chk("wr_data_out", data_out, last_rd);
        chk("wr_ready", {31'b0, ready}, 32'd1);
    endtask

    task automatic do_read(input logic [31:0] a, input bit h, input logic [31:0] d);
        push_exp(h, d, 0);
        enable = 1'b1; rw = 1'b0; address = a; data_in = '0;
        tick();
        enable = 1'b0;
        wait_drain();
    endtask

    task automatic do_reset();
        reset_n = 1'b1;
        tick();
        tick();
        reset_n = 1'b0;
        sb.delete();
        last_rd = '0;
        chk("rst_data_out", data_out, 32'd0);
        chk("rst_ready", {31'b0, ready}, 32'd1);
        chk("rst_hit", {31'b0, hit}, 32'd0);
    endtask

    initial begin
        reset_n = 1'b1; enable = 1'b0; rw = 1'b0; address = '0; data_in = '0;

        //             rw    addr          wdata         hit   data
        vecs[0]  = '{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 1'b0, 32'h0};
        vecs[1]  = '{1'b0, 32'h0000_0010, 32'h0,         1'b1, 32'hDEAD_BEEF};
        vecs[2]  = '{1'b0, 32'h0000_1000, 32'h0,         1'b0, 32'h0000_0000};
        vecs[3]  = '{1'b0, 32'h0000_1000, 32'h0,         1'b1, 32'h0000_0000};
        vecs[4]  = '{1'b0, 32'h0000_0050, 32'h0,         1'b0, 32'h0000_0000};
        vecs[5]  = '{1'b0, 32'h0000_0010, 32'h0,         1'b0, 32'hDEAD_BEEF};
        vecs[6]  = '{1'b0, 32'h0000_0010, 32'h0,         1'b1, 32'hDEAD_BEEF};
        vecs[7]  = '{1'b1, 32'h0000_0024, 32'hCAFE_F00D, 1'b0, 32'h0};
        vecs[8]  = '{1'b0, 32'h0000_0024, 32'h0,         1'b1, 32'hCAFE_F00D};
        vecs[9]  = '{1'b1, 32'h0000_0424, 32'h1111_2222, 1'b0, 32'h0};
        vecs[10] = '{1'b0, 32'h0000_0024, 32'h0,         1'b0, 32'hCAFE_F00D};
        vecs[11] = '{1'b0, 32'h0000_0424, 32'h0,         1'b0, 32'h1111_2222};
        vecs[12] = '{1'b0, 32'h0000_1024, 32'h0,         1'b0, 32'hCAFE_F00D};
        vecs[13] = '{1'b0, 32'h0000_1024, 32'h0,         1'b1, 32'hCAFE_F00D};
        vecs[14] = '{1'b1, 32'hFFFF_FFFC, 32'hA5A5_A5A5, 1'b0, 32'h0};
        vecs[15] = '{1'b0, 32'hFFFF_FFFF, 32'h0,         1'b1, 32'hA5A5_A5A5};
        vecs[16] = '{1'b0, 32'h0000_0FFC, 32'h0,         1'b0, 32'hA5A5_A5A5};
        vecs[17] = '{1'b0, 32'h0000_0013, 32'h0,         1'b1, 32'hDEAD_BEEF};

        tick();
        do_reset();

        // Write held for two edges, then idle: data_out stays 0.
        enable = 1'b1; rw = 1'b1; address = 32'h10; data_in = 32'hDEAD_BEEF;
        for (int k = 0; k < 2; k++) begin
            tick();
            chk("held_wr_data_out", data_out, 32'd0);
            chk("held_wr_hit", {31'b0, hit}, 32'd0);
        end
        enable = 1'b0;
        tick();
        chk("idle_ready", {31'b0, ready}, 32'd1);

        // Table-driven vectors.
        for (int i = 0; i < c_NVEC; i++) begin
            if (vecs[i].rw) do_write(vecs[i].addr, vecs[i].wdata);
            else            do_read(vecs[i].addr, vecs[i].exp_hit, vecs[i].exp_data);
        end

        // Read held for three edges: three back-to-back hits.
        for (int k = 0; k < 3; k++) push_exp(1'b1, 32'hDEAD_BEEF, k);
        enable = 1'b1; rw = 1'b0; address = 32'h10;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("held_rd_ready", {31'b0, ready}, 32'd1);
        end
        enable = 1'b0;
        wait_drain();

        // Requests during MISS_WAIT are dropped: a write and a read.
        push_exp(1'b0, 32'h0, 0);
        enable = 1'b1; rw = 1'b0; address = 32'h2028;
        tick();
        rw = 1'b1; data_in = 32'h7777_7777;
        tick();
        chk("mw_ready", {31'b0, ready}, 32'd0);
        rw = 1'b0; address = 32'h10;
        tick();
        chk("mw_ready2", {31'b0, ready}, 32'd0);
        enable = 1'b0;
        wait_drain();
        do_read(32'h2028, 1'b1, 32'h0);
        do_read(32'h0028, 1'b0, 32'h0);

        // Reset in the middle of a miss: no fill, no data_out update.
        do_read(32'h0000_0050, 1'b0, 32'h0);
        do_read(32'h0000_0010, 1'b0, 32'hDEAD_BEEF);
        push_exp(1'b0, 32'h0, 0);
        enable = 1'b1; rw = 1'b0; address = 32'h50;
        tick();
        enable = 1'b0;
        tick();
        chk("pre_rst_ready", {31'b0, ready}, 32'd0);
        reset_n = 1'b1;
        tick();
        reset_n = 1'b0;
        sb.delete();
        last_rd = '0;
        chk("midmiss_rst_data_out", data_out, 32'd0);
        chk("midmiss_rst_ready", {31'b0, ready}, 32'd1);
        for (int k = 0; k < 4; k++) tick();
        chk("post_rst_data_out", data_out, 32'd0);
        chk("post_rst_hit", {31'b0, hit}, 32'd0);
        do_read(32'h0000_0010, 1'b0, 32'hDEAD_BEEF);
        do_read(32'h0000_0010, 1'b1, 32'hDEAD_BEEF);
        do_read(32'h0000_0050, 1'b0, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
